// File: rtl/arp_cache.sv
// IP-to-MAC cache answering MAC lookups; a miss triggers ARP requests with
// timeout and retry. State table: IDLE | accept query ; LOOKUP | compare table ;
// REQUEST | hand target IP to ARP tx ; WAIT | reply or timeout ; RESPOND | hold result
module arp_cache #(
    parameter int CACHE_DEPTH    = 8,
    parameter int TIMEOUT_CYCLES = 20_000_000,
    parameter int RETRY_COUNT    = 3
) (
    input  logic        logic_clk,
    input  logic        logic_rst,
    input  logic        arp_update_valid_in,
    input  logic [31:0] arp_update_ip_in,
    input  logic [47:0] arp_update_mac_in,
    input  logic [31:0] arp_query_ip_in,
    input  logic        arp_query_valid_in,
    output logic        arp_query_ready_out,
    output logic [47:0] arp_response_mac_out,
    output logic        arp_response_valid_out,
    input  logic        arp_response_ready_in,
    output logic        arp_response_err_out,
    output logic        trig_arp_qvalid_out,
    output logic [31:0] trig_arp_ip_out,
    input  logic        trig_arp_qready_in
);
    localparam int PTR_W   = $clog2(CACHE_DEPTH);
    localparam int RETRY_W = $clog2(RETRY_COUNT + 1);
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, REQUEST, WAIT, RESPOND} state_t;

    logic [CACHE_DEPTH-1:0] entry_valid;
    logic [31:0]            entry_ip  [CACHE_DEPTH];
    logic [47:0]            entry_mac [CACHE_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;

    state_t             state;
    logic [31:0]        query_ip;
    logic [RETRY_W-1:0] retry;
    logic [TIMER_W-1:0] timer;

    logic               upd_hit;
    logic [PTR_W-1:0]   upd_idx;
    logic               lk_hit;
    logic [47:0]        lk_mac;

    // Entries never hold duplicate IPs, so OR-reducing the matching MACs is exact.
    always_comb begin
        upd_hit = 1'b0;
        upd_idx = '0;
        lk_hit  = (query_ip == 32'hFFFF_FFFF);
        lk_mac  = lk_hit ? 48'hFFFF_FFFF_FFFF : 48'h0;
        for (int i = 0; i < CACHE_DEPTH; i++) begin
            if (entry_valid[i] && entry_ip[i] == arp_update_ip_in) begin
                upd_hit = 1'b1;
                upd_idx = PTR_W'(i);
            end
            if (entry_valid[i] && entry_ip[i] == query_ip) begin
                lk_hit = 1'b1;
                lk_mac = lk_mac | entry_mac[i];
            end
        end
    end

    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            entry_valid <= '0;
            wr_ptr      <= '0;
        end else if (arp_update_valid_in && arp_update_ip_in != 32'h0) begin
            if (upd_hit) begin
                entry_mac[upd_idx] <= arp_update_mac_in;
            end else begin
                entry_valid[wr_ptr] <= 1'b1;
                entry_ip[wr_ptr]    <= arp_update_ip_in;
                entry_mac[wr_ptr]   <= arp_update_mac_in;
                wr_ptr              <= wr_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            state                  <= IDLE;
            query_ip               <= '0;
            retry                  <= '0;
            timer                  <= '0;
            arp_query_ready_out    <= 1'b0;
            arp_response_valid_out <= 1'b0;
            arp_response_mac_out   <= '0;
            arp_response_err_out   <= 1'b0;
            trig_arp_qvalid_out    <= 1'b0;
            trig_arp_ip_out        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    arp_query_ready_out <= 1'b1;
                    if (arp_query_valid_in && arp_query_ready_out) begin
                        arp_query_ready_out <= 1'b0;
                        query_ip            <= arp_query_ip_in;
                        state               <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lk_hit) begin
                        arp_response_mac_out <= lk_mac;
                        arp_response_err_out <= 1'b0;
                        state                <= RESPOND;
                    end else begin
                        retry               <= '0;
                        trig_arp_qvalid_out <= 1'b1;
                        trig_arp_ip_out     <= query_ip;
                        state               <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (trig_arp_qready_in) begin
                        trig_arp_qvalid_out <= 1'b0;
                        timer               <= '0;
                        state               <= WAIT;
                    end
                end
                WAIT: begin
                    // A reply landing on the timeout cycle still counts as a hit.
                    if (lk_hit) begin
                        arp_response_mac_out <= lk_mac;
                        arp_response_err_out <= 1'b0;
                        state                <= RESPOND;
                    end else if (timer == TIMER_LAST) begin
                        if (int'(retry) + 1 < RETRY_COUNT) begin
                            retry               <= retry + RETRY_W'(1);
                            trig_arp_qvalid_out <= 1'b1;
                            trig_arp_ip_out     <= query_ip;
                            state               <= REQUEST;
                        end else begin
                            arp_response_mac_out <= '0;
                            arp_response_err_out <= 1'b1;
                            state                <= RESPOND;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                RESPOND: begin
                    // Valid rises one cycle after entry so a hit answers two edges after accept.
                    if (!arp_response_valid_out) begin
                        arp_response_valid_out <= 1'b1;
                    end else if (arp_response_ready_in) begin
                        arp_response_valid_out <= 1'b0;
                        arp_query_ready_out    <= 1'b1;
                        state                  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arp_cache.sv
// Self-checking bench for arp_cache: directed vector table, reset-in-WAIT
// sequence and randomized queries against a FIFO-eviction cache model.
module tb_arp_cache;
    localparam int DEPTH   = 8;
    localparam int TMO     = 64;
    localparam int RETRIES = 3;

    logic        logic_clk = 1'b0;
    logic        logic_rst;
    logic        arp_update_valid_in;
    logic [31:0] arp_update_ip_in;
    logic [47:0] arp_update_mac_in;
    logic [31:0] arp_query_ip_in;
    logic        arp_query_valid_in;
    logic        arp_query_ready_out;
    logic [47:0] arp_response_mac_out;
    logic        arp_response_valid_out;
    logic        arp_response_ready_in;
    logic        arp_response_err_out;
    logic        trig_arp_qvalid_out;
    logic [31:0] trig_arp_ip_out;
    logic        trig_arp_qready_in;

    always #5 logic_clk = ~logic_clk;

    arp_cache #(
        .CACHE_DEPTH   (DEPTH),
        .TIMEOUT_CYCLES(TMO),
        .RETRY_COUNT   (RETRIES)
    ) dut (
        .logic_clk             (logic_clk),
        .logic_rst             (logic_rst),
        .arp_update_valid_in   (arp_update_valid_in),
        .arp_update_ip_in      (arp_update_ip_in),
        .arp_update_mac_in     (arp_update_mac_in),
        .arp_query_ip_in       (arp_query_ip_in),
        .arp_query_valid_in    (arp_query_valid_in),
        .arp_query_ready_out   (arp_query_ready_out),
        .arp_response_mac_out  (arp_response_mac_out),
        .arp_response_valid_out(arp_response_valid_out),
        .arp_response_ready_in (arp_response_ready_in),
        .arp_response_err_out  (arp_response_err_out),
        .trig_arp_qvalid_out   (trig_arp_qvalid_out),
        .trig_arp_ip_out       (trig_arp_ip_out),
        .trig_arp_qready_in    (trig_arp_qready_in)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge logic_clk);
        #1;
    endtask

    // Reference cache: insertion-ordered list, oldest insertion evicted first.
    typedef struct { logic [31:0] ip; logic [47:0] mac; } bind_t;
    bind_t m_q[$];

    function automatic void m_update(input logic [31:0] ip, input logic [47:0] mac);
        if (ip == 32'h0) return;
        foreach (m_q[i]) begin
            if (m_q[i].ip == ip) begin
                m_q[i].mac = mac;
                return;
            end
        end
        m_q.push_back('{ip, mac});
        if (m_q.size() > DEPTH) void'(m_q.pop_front());
    endfunction

    function automatic bit m_lookup(input logic [31:0] ip, output logic [47:0] mac);
        mac = '0;
        if (ip == 32'hFFFF_FFFF) begin
            mac = 48'hFFFF_FFFF_FFFF;
            return 1'b1;
        end
        foreach (m_q[i]) begin
            if (m_q[i].ip == ip) begin
                mac = m_q[i].mac;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic do_update(input logic [31:0] ip, input logic [47:0] mac);
        arp_update_ip_in    = ip;
        arp_update_mac_in   = mac;
        arp_update_valid_in = 1'b1;
        m_update(ip, mac);
        tick();
        arp_update_valid_in = 1'b0;
    endtask

    // Drives one query; acts as ARP transmitter (qready after 'hold' cycles) and
    // optionally as ARP receiver (update 'reply_at' cycles after the first handshake).
    task automatic run_query(input logic [31:0] ip, input int hold, input int reply_at,
                             input logic [47:0] reply_mac, input int bp,
                             output logic [47:0] mac, output logic err, output int ntrig,
                             output int lat, output int gmin, output int gmax,
                             output bit ok, output bit fin);
        int cyc, hold_c, bp_c, since_hs, last_hs;
        bit seen, pending;
        mac = '0; err = 1'b0; ntrig = 0; lat = -1; gmin = 1 << 30; gmax = 0;
        ok = 1'b1; fin = 1'b0; seen = 1'b0; pending = 1'b0;
        hold_c = 0; bp_c = 0; since_hs = 0; last_hs = 0;
        arp_query_ip_in    = ip;
        arp_query_valid_in = 1'b1;
        cyc = 0;
        while (!arp_query_ready_out && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!arp_query_ready_out) ok = 1'b0;
        tick();
        arp_query_valid_in = 1'b0;
        cyc = 0;
        while (!fin && cyc < 600) begin
            tick();
            cyc++;
            arp_update_valid_in = 1'b0;
            trig_arp_qready_in  = 1'b0;
            if (pending) begin
                arp_response_ready_in = 1'b0;
                fin = 1'b1;
            end else begin
                if (arp_query_ready_out) ok = 1'b0;
                if (trig_arp_qvalid_out) begin
                    if (trig_arp_ip_out !== ip) ok = 1'b0;
                    if (hold_c >= hold) begin
                        trig_arp_qready_in = 1'b1;
                        ntrig++;
                        if (ntrig > 1) begin
                            if (cyc - last_hs < gmin) gmin = cyc - last_hs;
                            if (cyc - last_hs > gmax) gmax = cyc - last_hs;
                        end
                        last_hs = cyc;
                        hold_c  = 0;
                    end else begin
                        hold_c++;
                    end
                end
                if (ntrig > 0 && reply_at >= 0) begin
                    since_hs++;
                    if (since_hs == reply_at) begin
                        arp_update_ip_in    = ip;
                        arp_update_mac_in   = reply_mac;
                        arp_update_valid_in = 1'b1;
                        m_update(ip, reply_mac);
                    end
                end
                if (arp_response_valid_out) begin
                    if (!seen) begin
                        seen = 1'b1;
                        lat  = cyc;
                        mac  = arp_response_mac_out;
                        err  = arp_response_err_out;
                    end else if (arp_response_mac_out !== mac || arp_response_err_out !== err) begin
                        ok = 1'b0;
                    end
                    if (bp_c >= bp) begin
                        arp_response_ready_in = 1'b1;
                        pending = 1'b1;
                    end else begin
                        bp_c++;
                    end
                end
            end
        end
        arp_update_valid_in   = 1'b0;
        trig_arp_qready_in    = 1'b0;
        arp_response_ready_in = 1'b0;
    endtask

    typedef struct {
        logic [31:0] qip;
        int          hold;
        int          reply_at;
        logic [47:0] reply_mac;
        int          bp;
        logic [47:0] exp_mac;
        logic        exp_err;
        int          exp_trig;
    } vec_t;

    task automatic apply_vec(input vec_t v, input string tag);
        logic [47:0] mac;
        logic        err;
        int          ntrig, lat, gmin, gmax;
        bit          ok, fin;
        run_query(v.qip, v.hold, v.reply_at, v.reply_mac, v.bp, mac, err, ntrig, lat, gmin, gmax, ok, fin);
        check({tag, ".finished"}, 64'(fin), 64'(1));
        check({tag, ".handshake"}, 64'(ok), 64'(1));
        check({tag, ".mac"}, 64'(mac), 64'(v.exp_mac));
        check({tag, ".err"}, 64'(err), 64'(v.exp_err));
        check({tag, ".trig_count"}, 64'(ntrig), 64'(v.exp_trig));
        if (v.exp_trig == 0) check({tag, ".latency"}, 64'(lat), 64'(2));
        if (v.exp_trig > 1) begin
            check({tag, ".gap_min"}, 64'(gmin), 64'(TMO + 1 + v.hold));
            check({tag, ".gap_max"}, 64'(gmax), 64'(TMO + 1 + v.hold));
        end
    endtask

    function automatic logic [31:0] pool_ip(input int k);
        return (k == 0) ? 32'h0 : 32'h0A00_0000 + 32'(k);
    endfunction

    vec_t vecs[10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'hC0A8_0001, 0, -1, 48'h0, 0,  48'h0011_2233_4455, 1'b0, 0};
        vecs[1] = '{32'hC0A8_0001, 0, -1, 48'h0, 10, 48'h0011_2233_4455, 1'b0, 0};
        vecs[2] = '{32'hFFFF_FFFF, 0, -1, 48'h0, 2,  48'hFFFF_FFFF_FFFF, 1'b0, 0};
        vecs[3] = '{32'hC0A8_0002, 5, 30, 48'h0A0B_0C0D_0E0F, 0, 48'h0A0B_0C0D_0E0F, 1'b0, 1};
        vecs[4] = '{32'hC0A8_0002, 0, -1, 48'h0, 0,  48'h0A0B_0C0D_0E0F, 1'b0, 0};
        vecs[5] = '{32'hC0A8_0003, 0, -1, 48'h0, 3,  48'h0, 1'b1, RETRIES};
        vecs[6] = '{32'hC0A8_0010, 2, 4, 48'h1234_5678_9ABC, 0, 48'h1234_5678_9ABC, 1'b0, 1};
        vecs[7] = '{32'hC0A8_0018, 0, -1, 48'h0, 0,  48'hAA00_0000_0018, 1'b0, 0};
        vecs[8] = '{32'hC0A8_0012, 0, -1, 48'h0, 1,  48'hBEEF_0000_0012, 1'b0, 0};
        vecs[9] = '{32'hC0A8_0013, 0, -1, 48'h0, 0,  48'hAA00_0000_0013, 1'b0, 0};

        logic_rst = 1'b1;
        arp_update_valid_in = 1'b0; arp_update_ip_in = '0; arp_update_mac_in = '0;
        arp_query_ip_in = '0; arp_query_valid_in = 1'b0;
        arp_response_ready_in = 1'b0; trig_arp_qready_in = 1'b0;
        repeat (3) tick();
        check("reset.query_ready", 64'(arp_query_ready_out), 64'(0));
        check("reset.resp_valid", 64'(arp_response_valid_out), 64'(0));
        check("reset.resp_mac", 64'(arp_response_mac_out), 64'(0));
        check("reset.resp_err", 64'(arp_response_err_out), 64'(0));
        check("reset.trig_valid", 64'(trig_arp_qvalid_out), 64'(0));
        check("reset.trig_ip", 64'(trig_arp_ip_out), 64'(0));
        logic_rst = 1'b0;
        tick();
        check("reset.ready_rises", 64'(arp_query_ready_out), 64'(1));

        do_update(32'hC0A8_0001, 48'h0011_2233_4455);
        do_update(32'h0, 48'hDEAD_DEAD_DEAD);
        for (int i = 0; i < 6; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 9; i++)
            do_update(32'hC0A8_0010 + 32'(i), 48'hAA00_0000_0010 + 48'(i));
        for (int i = 6; i < 8; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));
        do_update(32'hC0A8_0012, 48'hBEEF_0000_0012);
        for (int i = 8; i < 10; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while waiting for an ARP reply.
        begin
            int cyc;
            arp_query_ip_in    = 32'hC0A8_0020;
            arp_query_valid_in = 1'b1;
            cyc = 0;
            while (!arp_query_ready_out && cyc < 20) begin tick(); cyc++; end
            tick();
            arp_query_valid_in = 1'b0;
            cyc = 0;
            while (!trig_arp_qvalid_out && cyc < 10) begin tick(); cyc++; end
            check("rstwait.trig_seen", 64'(trig_arp_qvalid_out), 64'(1));
            trig_arp_qready_in = 1'b1;
            tick();
            trig_arp_qready_in = 1'b0;
            repeat (5) tick();
            check("rstwait.in_wait", 64'(trig_arp_qvalid_out), 64'(0));
            logic_rst = 1'b1;
            tick();
            check("rstwait.trig_low", 64'(trig_arp_qvalid_out), 64'(0));
            check("rstwait.valid_low", 64'(arp_response_valid_out), 64'(0));
            check("rstwait.ready_low", 64'(arp_query_ready_out), 64'(0));
            logic_rst = 1'b0;
            m_q.delete();
            tick();
            check("rstwait.ready_next", 64'(arp_query_ready_out), 64'(1));
            repeat (3) tick();
            check("rstwait.no_response", 64'(arp_response_valid_out), 64'(0));
            apply_vec('{32'hC0A8_0018, 0, 3, 48'h5555_6666_7777, 0, 48'h5555_6666_7777, 1'b0, 1}, "rstwait.relearn");
        end

        for (int it = 0; it < 40; it++) begin
            vec_t        v;
            logic [47:0] em;
            int          nu, k;
            nu = int'($urandom_range(0, 4));
            for (int u = 0; u < nu; u++)
                do_update(pool_ip(int'($urandom_range(0, 11))), {16'($urandom()), $urandom()});
            k = int'($urandom_range(1, 12));
            v.qip = (k == 12) ? 32'hFFFF_FFFF : pool_ip(k);
            v.hold = int'($urandom_range(0, 3));
            v.bp   = int'($urandom_range(0, 3));
            v.reply_mac = {16'($urandom()), $urandom()};
            if (m_lookup(v.qip, em)) begin
                v.reply_at = -1;
                v.exp_mac  = em;
                v.exp_err  = 1'b0;
                v.exp_trig = 0;
            end else if ($urandom_range(0, 7) == 0) begin
                v.reply_at = -1;
                v.exp_mac  = '0;
                v.exp_err  = 1'b1;
                v.exp_trig = RETRIES;
            end else begin
                v.reply_at = int'($urandom_range(1, 20));
                v.exp_mac  = v.reply_mac;
                v.exp_err  = 1'b0;
                v.exp_trig = 1;
            end
            apply_vec(v, $sformatf("rand%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
